// File: rtl/calc_job_arbiter.sv
// Job controller sharing one RPN calculator core between two clients: grant,
// program load, start, wait for halt (watchdog abort) and result return.
module calc_job_arbiter #(
   parameter int TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [9:0]  len0,
   input  logic [9:0]  len1,
   input  logic [1:0]  in_valid,
   input  logic [15:0] in_word0,
   input  logic [15:0] in_word1,
   output logic [1:0]  in_ready,
   output logic [1:0]  gnt,
   output logic [1:0]  done,
   output logic [15:0] result,
   output logic        err,
   output logic [9:0]  calc_addr,
   output logic        calc_wr,
   output logic [15:0] calc_datain,
   output logic        calc_start,
   output logic        calc_nrst,
   input  logic        calc_ready,
   input  logic [15:0] calc_out
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      ABORT = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic        last;
   logic        cur;
   logic [9:0]  len_q;
   logic [9:0]  wcnt;
   logic [15:0] tcnt;

   logic        win;
   logic [1:0]  win_oh;
   logic [9:0]  win_len;
   logic [15:0] word_sel;
   logic        accept;

   // Round-robin choice: on a tie the client that did not win last time goes.
   always_comb begin
      win = 1'b0;
      if (req == 2'b11) begin
         win = ~last;
      end else if (req[1]) begin
         win = 1'b1;
      end else begin
         win = 1'b0;
      end
   end

   assign win_oh   = win ? 2'b10 : 2'b01;
   assign win_len  = win ? len1 : len0;
   assign word_sel = cur ? in_word1 : in_word0;

   // Write strobe follows the handshake directly so a held valid streams one word per cycle.
   assign accept      = (state == LOAD) && in_ready[cur] && in_valid[cur];
   assign calc_wr     = accept;
   assign calc_addr   = wcnt;
   assign calc_datain = (state == LOAD) ? word_sel : 16'h0000;
   assign calc_nrst   = !rst && (state != ABORT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last       <= 1'b1;
         cur        <= 1'b0;
         len_q      <= 10'd0;
         wcnt       <= 10'd0;
         tcnt       <= 16'd0;
         gnt        <= 2'b00;
         in_ready   <= 2'b00;
         done       <= 2'b00;
         result     <= 16'h0000;
         err        <= 1'b0;
         calc_start <= 1'b0;
      end else begin
         done       <= 2'b00;
         calc_start <= 1'b0;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  cur   <= win;
                  last  <= win;
                  gnt   <= win_oh;
                  len_q <= win_len;
                  wcnt  <= 10'd0;
                  if (win_len == 10'd0) begin
                     err   <= 1'b1;
                     done  <= win_oh;
                     state <= DONE;
                  end else begin
                     in_ready <= win_oh;
                     state    <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  wcnt <= wcnt + 10'd1;
                  // Start is issued in its own cycle after the final write
                  if (wcnt + 10'd1 == len_q) begin
                     in_ready   <= 2'b00;
                     calc_start <= 1'b1;
                     state      <= START;
                  end
               end
            end
            START: begin
               tcnt  <= 16'd0;
               state <= WAIT;
            end
            WAIT: begin
               if (calc_ready) begin
                  result <= calc_out;
                  err    <= 1'b0;
                  done   <= gnt;
                  state  <= DONE;
               end else if (tcnt == TMO_LAST) begin
                  state <= ABORT;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            ABORT: begin
               result <= 16'h0000;
               err    <= 1'b1;
               done   <= gnt;
               state  <= DONE;
            end
            DONE: begin
               gnt   <= 2'b00;
               state <= IDLE;
            end
            default: begin
               gnt      <= 2'b00;
               in_ready <= 2'b00;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/calc_job_arbiter.md
# calc_job_arbiter

Job controller that shares one programmable RPN calculator core between two requesting clients. A granted client streams a program word-by-word, and the block writes it into the calculator's code memory from address 0. It then pulses start, waits for the calculator to halt, and returns the top-of-stack result to that client. A watchdog aborts runaway programs by resetting the calculator core.

## Interface

Parameters
- TIMEOUT, 4096: maximum WAIT cycles before abort; 1..65535.

Ports
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  per-client job request; held high until done.
- len0, len1  in  10  program length in words for client 0/1; sampled at grant.
- in_valid  in  2  per-client program word valid.
- in_word0, in_word1  in  16  program word from client 0/1.
- in_ready  out  2  word accepted; at most one bit high, only for the granted client in LOAD.
- gnt  out  2  one-hot grant, held from LOAD through DONE.
- done  out  2  one-cycle completion pulse to the granted client.
- result  out  16  calculator top of stack captured at halt; valid while done is high, holds until next capture.
- err  out  1  valid with done: 1 = timeout or len==0.
- calc_addr  out  10  code-memory write address.
- calc_wr  out  1  code-memory write enable.
- calc_datain  out  16  code-memory write data.
- calc_start  out  1  start pulse.
- calc_nrst  out  1  calculator reset, active low.
- calc_ready  in  1  calculator idle/halted (1 = READY).
- calc_out  in  16  calculator top of stack.

## Operation

- States: IDLE, LOAD, START, WAIT, ABORT, DONE.
- Reset values:
  - state=IDLE, gnt=0, in_ready=0, done=0, result=0, err=0.
  - calc_wr=0, calc_start=0, calc_addr=0, calc_datain=0.
  - last=1, so client 0 wins the first tie.
- calc_nrst = !rst && (state != ABORT). It is combinational and low throughout reset.
- IDLE:
  - If one req bit is high, grant that client.
  - If both are high, grant client != last. Update last to the winner.
  - Latch the winner's len into len_q and clear wcnt (10-bit) to 0.
  - Go to LOAD, or to DONE with err=1 if the latched len==0.
- LOAD:
  - in_ready[g]=1.
  - On in_valid[g]: calc_wr=1, calc_addr=wcnt, calc_datain=in_word[g], wcnt++.
  - When the accepted word makes wcnt==len_q, go to START.
  - calc_wr is combinational from in_valid[g] && in_ready[g].
  - in_valid of the non-granted client is ignored.
- START: calc_start=1 and calc_wr=0 for exactly one cycle. Clear tcnt (16-bit). Go to WAIT.
- WAIT:
  - If calc_ready==1: result<=calc_out, err<=0, go to DONE.
  - Otherwise tcnt++. If tcnt==TIMEOUT-1, go to ABORT.
- ABORT: calc_nrst=0 for one cycle. result<=0, err<=1. Go to DONE.
- DONE: done[g]=1 for one cycle. Clear gnt and go to IDLE.
- calc_wr is never high outside LOAD, and calc_start is never high outside START.
- Code memory is not cleared between jobs. Only words 0..len-1 are rewritten.
- Program encoding is the calculator's own:
  - bit15=0: push.
  - bit15:14=11: halt.
  - bit15=1, bit14=0, op 0..7: operation; op 7 is a jump to top of stack.

## Timing

- req seen in IDLE → gnt and in_ready at the next cycle (1-cycle grant latency).
- Throughput in LOAD: 1 word per cycle when in_valid is held high.
- The final word's write and the START cycle are separate cycles. calc_start therefore never coincides with calc_wr, because the core gates writes with !start.
- The core drops ready one cycle after calc_start. The first WAIT cycle therefore already sees calc_ready=0, so no extra guard cycle is needed.
- Total latency for a job of N words halting after K core cycles: 1 (IDLE) + N (LOAD) + 1 (START) + K (WAIT) + 1 (DONE), with in_valid held.
- Timeout: ABORT is entered after exactly TIMEOUT WAIT cycles with calc_ready low.
- req still high in the IDLE cycle after DONE is treated as a new job. Clients must drop req on the cycle done is seen.
- rst asserted mid-job:
  - Immediate return to IDLE, all outputs to reset values.
  - calc_nrst low for the duration of the reset.
  - No done is issued for the aborted job.

## Test plan

- Basic job: client 0, len=4, program 0x0005, 0x0003, 0x8002, 0xC000, in_valid held → calc_addr 0..3 written on consecutive cycles. calc_start fires 1 cycle after the last write. done[0]=1 with result=8, err=0.
- Contention: req=2'b11 from reset → client 0 served first, then client 1 in the IDLE cycle after DONE. Repeated simultaneous requests alternate 0,1,0,1.
- Stalled stream: client 1 deasserts in_valid for 3 cycles mid-LOAD (words 0x0007, 0x0002, 0x8003, 0xC000) → no calc_wr during the stall, addresses stay contiguous, result=14.
- Timeout: TIMEOUT=64, program 0x0000, 0x8007 (jump to 0, never halts) → ABORT after 64 WAIT cycles with calc_nrst low for 1 cycle, then done with err=1, result=0. A following valid job returns a correct result.
- len=0: req[0] with len0=0 → no calc_wr and no calc_start. done[0] 2 cycles after req with err=1.
- Reset mid-LOAD: rst high for 1 cycle after 2 words → gnt=0, in_ready=0, no done, calc_nrst low during reset. A re-issued job completes normally.
